// File: rtl/stream_sorter.sv
// stream_sorter: collects a batch of up to SIZE = 1 << DEPTH values, sorts it
// with an odd-even transposition network (SIZE cycles) and streams it back out.
// Optional: define STREAM_SORTER_IDX_EN to add out_idx, the arrival slot of
// each value, carried through every swap.
//
// state | meaning
// LOAD  | accepting input beats into slots 0..k-1
// SORT  | SIZE compare-swap cycles, alternating even/odd pairs
// DRAIN | presenting slots 0..k-1 on the output stream
module stream_sorter #(
  parameter int VALUE_BITS = 32,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dir,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_BITS-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VALUE_BITS-1:0] out_data,
  output logic                  out_last,
`ifdef STREAM_SORTER_IDX_EN
  output logic [DEPTH-1:0]      out_idx,
`endif
  output logic                  busy
);

  localparam int SIZE = 1 << DEPTH;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [VALUE_BITS-1:0] data_q [SIZE];
  logic [VALUE_BITS-1:0] data_s [SIZE];
  logic [SIZE-1:0]       occ_q, occ_s;
`ifdef STREAM_SORTER_IDX_EN
  logic [DEPTH-1:0]      idx_q [SIZE];
  logic [DEPTH-1:0]      idx_s [SIZE];
`endif
  logic [DEPTH:0]        cnt_q;
  logic [DEPTH-1:0]      sort_cnt_q;
  logic [DEPTH-1:0]      rd_ptr_q;
  logic                  dir_q;
  logic                  in_fire, out_fire, load_done, sort_done;

  // An unoccupied slot always belongs behind an occupied one; equal values stay put.
  function automatic logic must_swap(input logic [VALUE_BITS-1:0] a,
                                     input logic [VALUE_BITS-1:0] b,
                                     input logic oa, input logic ob,
                                     input logic d);
    if (!oa) return ob;
    if (!ob) return 1'b0;
    return d ? (a < b) : (a > b);
  endfunction

  assign in_fire   = in_valid && (state_q == LOAD);
  assign out_fire  = out_valid && out_ready;
  assign load_done = (cnt_q == (DEPTH+1)'(SIZE-1)) || in_last;
  assign sort_done = (sort_cnt_q == DEPTH'(SIZE-1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && load_done) state_d = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_d = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && out_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Output beat: slot rd_ptr; zero outside DRAIN so reset shows a clean bus.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
`ifdef STREAM_SORTER_IDX_EN
    out_idx  = '0;
`endif
    if (state_q == DRAIN) begin
      out_data = data_q[rd_ptr_q];
      out_last = ({1'b0, rd_ptr_q} == (cnt_q - 1'b1));
`ifdef STREAM_SORTER_IDX_EN
      out_idx  = idx_q[rd_ptr_q];
`endif
    end
  end

  // One transposition step: even pairs when sort_cnt is even, odd pairs otherwise.
  always_comb begin
    data_s = data_q;
    occ_s  = occ_q;
`ifdef STREAM_SORTER_IDX_EN
    idx_s  = idx_q;
`endif
    for (int i = 0; i < SIZE - 1; i++) begin
      if (i[0] == sort_cnt_q[0] &&
          must_swap(data_q[i], data_q[i+1], occ_q[i], occ_q[i+1], dir_q)) begin
        data_s[i]   = data_q[i+1];
        data_s[i+1] = data_q[i];
        occ_s[i]    = occ_q[i+1];
        occ_s[i+1]  = occ_q[i];
`ifdef STREAM_SORTER_IDX_EN
        idx_s[i]    = idx_q[i+1];
        idx_s[i+1]  = idx_q[i];
`endif
      end
    end
  end

  // Slot storage, batch counters and the latched sort direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        data_q[i] <= '0;
`ifdef STREAM_SORTER_IDX_EN
        idx_q[i]  <= '0;
`endif
      end
      occ_q      <= '0;
      cnt_q      <= '0;
      sort_cnt_q <= '0;
      rd_ptr_q   <= '0;
      dir_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          sort_cnt_q <= '0;
          rd_ptr_q   <= '0;
          if (in_fire) begin
            data_q[cnt_q[DEPTH-1:0]] <= in_data;
            occ_q[cnt_q[DEPTH-1:0]]  <= 1'b1;
`ifdef STREAM_SORTER_IDX_EN
            idx_q[cnt_q[DEPTH-1:0]]  <= cnt_q[DEPTH-1:0];
`endif
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '0) dir_q <= dir;
          end
        end
        SORT: begin
          data_q     <= data_s;
          occ_q      <= occ_s;
`ifdef STREAM_SORTER_IDX_EN
          idx_q      <= idx_s;
`endif
          sort_cnt_q <= sort_cnt_q + 1'b1;
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last) begin
              occ_q    <= '0;
              cnt_q    <= '0;
              rd_ptr_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sorter.sv
// Scoreboard bench for stream_sorter (DEPTH=3, VALUE_BITS=32).
module tb_stream_sorter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dir = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef STREAM_SORTER_IDX_EN
  logic [2:0]  out_idx;
`endif

  stream_sorter #(.VALUE_BITS(32), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
`ifdef STREAM_SORTER_IDX_EN
    .out_idx(out_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          ix;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = 0;
  logic ov_prev = 1'b0;
  logic bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output pattern 1,0,0 repeating while backpressure is enabled.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? (k % 3 == 0) : 1'b1;
      k++;
    end
  end

  // Monitor: latency, in_ready while draining, and scoreboard comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) last_hs = cyc;
      if (out_valid && !ov_prev) chk("latency", cyc - last_hs, 9);
      if (out_valid) begin
        chk("in_ready_drain", {31'b0, in_ready}, 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, q[0].d);
          chk("out_last", {31'b0, out_last}, {31'b0, q[0].l});
`ifdef STREAM_SORTER_IDX_EN
          chk("out_idx", {29'b0, out_idx}, q[0].ix);
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic push_exp(input logic [31:0] e[8], input int ix[8], input int n);
    for (int j = 0; j < n; j++) q.push_back('{d: e[j], l: (j == n - 1), ix: ix[j]});
  endtask

  // Drives n beats; dir is d0 on the first beat and d_rest afterwards.
  task automatic send(input logic [31:0] v[8], input int n, input logic use_last,
                      input logic d0, input logic d_rest);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = v[j];
      in_last  = use_last && (j == n - 1);
      dir      = (j == 0) ? d0 : d_rest;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready && !out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: got timeout expected idle, %0d beats pending", q.size());
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_out_last"}, {31'b0, out_last}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_out_data"}, out_data, 0);
`ifdef STREAM_SORTER_IDX_EN
    chk({tag, "_out_idx"}, {29'b0, out_idx}, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v[8];
    logic [31:0] e[8];
    int          ix[8];

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full ascending batch.
    v  = '{7, 3, 9, 1, 8, 2, 6, 4};
    e  = '{1, 2, 3, 4, 6, 7, 8, 9};
    ix = '{3, 5, 1, 7, 6, 0, 4, 2};
    push_exp(e, ix, 8);
    send(v, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Descending, in_last on the 8th beat, dir flips after first beat (must be ignored).
    e  = '{9, 8, 7, 6, 4, 3, 2, 1};
    ix = '{2, 4, 0, 6, 7, 1, 5, 3};
    push_exp(e, ix, 8);
    send(v, 8, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Partial batch with a tie.
    v  = '{5, 0, 5, 0, 0, 0, 0, 0};
    e  = '{0, 5, 5, 0, 0, 0, 0, 0};
    ix = '{1, 0, 2, 0, 0, 0, 0, 0};
    push_exp(e, ix, 3);
    send(v, 3, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Backpressure during DRAIN.
    v  = '{40, 10, 30, 20, 80, 60, 50, 70};
    e  = '{10, 20, 30, 40, 50, 60, 70, 80};
    ix = '{1, 3, 2, 0, 6, 5, 7, 4};
    bp_en = 1'b1;
    push_exp(e, ix, 8);
    send(v, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    bp_en = 1'b0;

    // Reset asserted on the 4th SORT cycle discards the batch.
    v = '{11, 22, 33, 44, 55, 66, 77, 88};
    send(v, 8, 1'b0, 1'b0, 1'b0);
    chk("sort_busy", {31'b0, busy}, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 1);
    chk("post_reset_busy", {31'b0, busy}, 0);

    v  = '{15, 3, 3, 0, 12, 7, 1, 9};
    e  = '{15, 12, 9, 7, 3, 3, 1, 0};
    ix = '{0, 4, 7, 5, 1, 2, 6, 3};
    push_exp(e, ix, 8);
    send(v, 8, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Unsigned extremes; stale data left in unoccupied slots must stay behind.
    v  = '{32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
    e  = '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0};
    ix = '{1, 3, 0, 2, 0, 0, 0, 0};
    push_exp(e, ix, 4);
    send(v, 4, 1'b1, 1'b0, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
